// File: rtl/lockin_frame_builder_if.sv
// lockin_frame_builder_if -- AXI-Stream style output bus of the frame builder.
//   tvalid : word valid (master -> slave)
//   tready : downstream ready (slave -> master)
//   tdata  : 24-bit averaged amplitude
//   tlast  : last word of a frame
interface lockin_frame_builder_if;
  logic        tvalid;
  logic        tready;
  logic [23:0] tdata;
  logic        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/lockin_frame_builder.sv
// lockin_frame_builder -- averages lock-in amplitude samples in groups of
// 2^AVG_LOG2 and streams FRAME_LEN averaged words per armed frame through a
// FIFO_DEPTH-word output FIFO with a registered head.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   frame_start        : one-cycle pulse, arms one frame (ignored unless idle)
//   lock_tdata_valid   : sample strobe
//   lock_tdata[23:0]   : unsigned amplitude sample
//   m_axis             : output stream (tvalid/tready/tdata/tlast), master side
//   frame_busy         : frame armed and its last word not yet accepted
//   overflow           : sticky, an average was dropped on a full FIFO
//
// Build option: define LOCKIN_AVG_ROUND_EN for round-half-up averaging with
// saturation; otherwise the average is a plain truncating shift.
module lockin_frame_builder #(
  parameter int AVG_LOG2   = 4,
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  frame_start,
  input  logic                  lock_tdata_valid,
  input  logic [23:0]           lock_tdata,
  lockin_frame_builder_if.master m_axis,
  output logic                  frame_busy,
  output logic                  overflow
);
  localparam int ACC_W = 24 + AVG_LOG2;
  localparam int WC_W  = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [AVG_LOG2-1:0] r_smp_cnt;
  logic [WC_W-1:0]    r_word_cnt;
  logic [23:0]        r_avg;
  logic               r_avg_vld;
  logic               r_ovf;

  // FIFO: memory plus a registered head; r_level counts both, so the
  // total capacity is exactly FIFO_DEPTH words.
  logic [24:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W:0]     r_wp, r_rp;
  logic [LVL_W-1:0]   r_level;
  logic               r_out_vld, r_out_last;
  logic [23:0]        r_out_data;

  logic               w_start, w_smp, w_last_smp, w_wr, w_wr_ok, w_tlast_in;
  logic               w_full, w_hs, w_mem_empty, w_load;
  logic [ACC_W-1:0]   w_sum;
  logic [23:0]        w_avg;

  assign w_start    = (r_state == S_IDLE) && frame_start;
  assign w_smp      = (r_state == S_COLLECT) && lock_tdata_valid;
  assign w_last_smp = w_smp && (r_smp_cnt == '1);
  assign w_sum      = r_acc + {{AVG_LOG2{1'b0}}, lock_tdata};

`ifdef LOCKIN_AVG_ROUND_EN
  localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (AVG_LOG2 - 1);
  logic [ACC_W:0] w_rnd;
  assign w_rnd = {1'b0, w_sum} + RND_HALF;
  assign w_avg = (|w_rnd[ACC_W:AVG_LOG2+24]) ? 24'hFFFFFF : w_rnd[AVG_LOG2+23:AVG_LOG2];
`else
  assign w_avg = w_sum[ACC_W-1:AVG_LOG2];
`endif

  assign w_hs        = r_out_vld && m_axis.tready;
  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_wr        = r_avg_vld && (r_state == S_COLLECT);
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_wr_ok     = w_wr && (!w_full || w_hs);
  assign w_tlast_in  = (r_word_cnt == WC_W'(FRAME_LEN - 1));
  assign w_mem_empty = (r_wp == r_rp);
  assign w_load      = !w_mem_empty && (!r_out_vld || w_hs);

  // FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (frame_start)            w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_wr_ok && w_tlast_in)  w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_hs && r_out_last)     w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_busy = (r_state != S_IDLE);
    overflow   = r_ovf;
  end

  // Averaging datapath and frame counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_acc      <= '0;
      r_smp_cnt  <= '0;
      r_word_cnt <= '0;
      r_avg      <= '0;
      r_avg_vld  <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_start) begin
      r_acc      <= '0;
      r_smp_cnt  <= '0;
      r_word_cnt <= '0;
      r_avg_vld  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_avg_vld <= w_last_smp;
      if (w_last_smp) r_avg <= w_avg;
      if (w_smp) begin
        r_smp_cnt <= r_smp_cnt + AVG_LOG2'(1);
        // Restart at 0 rather than at the current sample: that sample
        // already went into this average.
        r_acc     <= w_last_smp ? '0 : w_sum;
      end
      if (w_wr_ok)          r_word_cnt <= r_word_cnt + WC_W'(1);
      if (w_wr && !w_wr_ok) r_ovf      <= 1'b1;
    end
  end

  // FIFO storage (no reset needed: pointers define validity)
  always_ff @(posedge sys_clk) begin
    if (w_wr_ok) r_mem[r_wp[PTR_W-1:0]] <= {w_tlast_in, r_avg};
  end

  // FIFO pointers, level and registered head
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + (PTR_W+1)'(1);
      if (w_load) begin
        r_rp       <= r_rp + (PTR_W+1)'(1);
        r_out_vld  <= 1'b1;
        r_out_last <= r_mem[r_rp[PTR_W-1:0]][24];
        r_out_data <= r_mem[r_rp[PTR_W-1:0]][23:0];
      end else if (w_hs) begin
        r_out_vld  <= 1'b0;
      end
      case ({w_wr_ok, w_hs})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign m_axis.tvalid = r_out_vld;
  assign m_axis.tdata  = r_out_data;
  assign m_axis.tlast  = r_out_last;
endmodule

// File: tb/tb_lockin_frame_builder.sv
// Bench for lockin_frame_builder: two instances (FRAME_LEN 4 and 8, AVG_LOG2 2,
// FIFO_DEPTH 4). Expected words are queued when the completing sample is
// driven and popped by a monitor at each handshake.
module tb_lockin_frame_builder;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fs4 = 1'b0, vld4 = 1'b0, fs8 = 1'b0, vld8 = 1'b0;
  logic [23:0] dat = '0;
  logic        busy4, ovf4, busy8, ovf8;
  logic [24:0] q4[$], q8[$];
  logic [24:0] e4, e8;
  int          n_chk = 0, n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  lockin_frame_builder_if m4();
  lockin_frame_builder_if m8();

  lockin_frame_builder #(.AVG_LOG2(2), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(fs4),
    .lock_tdata_valid(vld4), .lock_tdata(dat), .m_axis(m4.master),
    .frame_busy(busy4), .overflow(ovf4));

  lockin_frame_builder #(.AVG_LOG2(2), .FRAME_LEN(8), .FIFO_DEPTH(4)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(fs8),
    .lock_tdata_valid(vld8), .lock_tdata(dat), .m_axis(m8.master),
    .frame_busy(busy8), .overflow(ovf8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && m4.tvalid && m4.tready) begin
      if (q4.size() == 0) chk("dut4_extra_word", 32'(q4.size()), 32'd1);
      else begin
        e4 = q4.pop_front();
        chk("dut4_tdata", 32'(m4.tdata), 32'(e4[23:0]));
        chk("dut4_tlast", 32'(m4.tlast), 32'(e4[24]));
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && m8.tvalid && m8.tready) begin
      if (q8.size() == 0) chk("dut8_extra_word", 32'(q8.size()), 32'd1);
      else begin
        e8 = q8.pop_front();
        chk("dut8_tdata", 32'(m8.tdata), 32'(e8[23:0]));
        chk("dut8_tlast", 32'(m8.tlast), 32'(e8[24]));
      end
    end
  end

  task automatic drive(input int sel, input logic fs, input logic v, input logic [23:0] d);
    @(posedge sys_clk); #1;
    fs4 = (sel == 0) && fs; vld4 = (sel == 0) && v;
    fs8 = (sel == 1) && fs; vld8 = (sel == 1) && v;
    dat = d;
  endtask

  task automatic smp(input int sel, input logic [23:0] d);
    drive(sel, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic start(input int sel);
    drive(sel, 1'b1, 1'b0, 24'd0);
  endtask

  // Four identical samples forming one average; expected word is queued.
  task automatic group(input int sel, input logic [23:0] v, input logic last, input logic push);
    for (int i = 0; i < 4; i++) smp(sel, v);
    if (push) begin
      if (sel == 0) q4.push_back({last, v});
      else          q8.push_back({last, v});
    end
  endtask

  task automatic wait_empty(input int sel);
    for (int i = 0; i < 300; i++) begin
      if ((sel == 0 ? q4.size() : q8.size()) == 0) break;
      @(negedge sys_clk);
    end
    chk(sel == 0 ? "dut4_drain" : "dut8_drain", 32'(sel == 0 ? q4.size() : q8.size()), 32'd0);
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_tvalid"}, 32'(m4.tvalid), 32'd0);
    chk({tag, "_tdata"},  32'(m4.tdata),  32'd0);
    chk({tag, "_tlast"},  32'(m4.tlast),  32'd0);
    chk({tag, "_busy"},   32'(busy4),     32'd0);
    chk({tag, "_ovf"},    32'(ovf4),      32'd0);
  endtask

  initial begin
    m4.tready = 1'b1;
    m8.tready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_zero4("reset");
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    // Steady frame of 100s; a second frame_start mid-frame must be ignored.
    start(0);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) drive(0, (g == 1 && i == 2), 1'b1, 24'd100);
      q4.push_back({g == 3, 24'd100});
      if (g == 1) begin @(negedge sys_clk); chk("busy_mid", 32'(busy4), 32'd1); end
    end
    idle(1);
    wait_empty(0);
    @(negedge sys_clk);
    chk("busy_after_last", 32'(busy4), 32'd0);

    // Averaging arithmetic: 1,2,3,4 -> 2 truncated, 3 rounded.
    start(0);
    smp(0, 24'd1); smp(0, 24'd2); smp(0, 24'd3); smp(0, 24'd4);
`ifdef LOCKIN_AVG_ROUND_EN
    q4.push_back({1'b0, 24'd3});
`else
    q4.push_back({1'b0, 24'd2});
`endif
    group(0, 24'd8, 1'b0, 1'b1);
    group(0, 24'd8, 1'b0, 1'b1);
    group(0, 24'd8, 1'b1, 1'b1);
    idle(1);
    wait_empty(0);

    // Full-scale samples must not wrap.
    idle(2);
    start(0);
    group(0, 24'hFFFFFF, 1'b0, 1'b1);
    group(0, 24'd0, 1'b0, 1'b1);
    group(0, 24'd0, 1'b0, 1'b1);
    group(0, 24'd0, 1'b1, 1'b1);
    idle(1);
    wait_empty(0);

    // Backpressure: whole frame held, extra samples after frame ignored.
    idle(2);
    m4.tready = 1'b0;
    start(0);
    group(0, 24'd10, 1'b0, 1'b1);
    group(0, 24'd20, 1'b0, 1'b1);
    group(0, 24'd30, 1'b0, 1'b1);
    group(0, 24'd40, 1'b1, 1'b1);
    group(0, 24'd99, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("hold_tvalid", 32'(m4.tvalid), 32'd1);
      chk("hold_tdata",  32'(m4.tdata),  32'd10);
      chk("hold_tlast",  32'(m4.tlast),  32'd0);
    end
    chk("hold_ovf", 32'(ovf4), 32'd0);
    @(posedge sys_clk); #1 m4.tready = 1'b1;
    wait_empty(0);
    @(negedge sys_clk);
    chk("hold_busy_end", 32'(busy4), 32'd0);

    // Reset mid-frame discards everything; samples without start are ignored.
    idle(2);
    m4.tready = 1'b0;
    start(0);
    for (int i = 0; i < 6; i++) smp(0, 24'd7);
    idle(3);
    #1 sys_rst_n = 1'b0;
    q4.delete();
    #2 chk_zero4("async_rst");
    idle(2);
    #1 sys_rst_n = 1'b1;
    m4.tready = 1'b1;
    for (int i = 0; i < 4; i++) smp(0, 24'd9);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("post_rst_tvalid", 32'(m4.tvalid), 32'd0);
    end
    chk_zero4("post_rst");

    // Overflow: depth 4, frame 8, fifth average dropped while stalled.
    start(1);
    for (int g = 1; g <= 5; g++) group(1, 24'(g * 1000), 1'b0, g <= 4);
    idle(4);
    chk("ovf_set",  32'(ovf8),  32'd1);
    chk("ovf_busy", 32'(busy8), 32'd1);
    @(posedge sys_clk); #1 m8.tready = 1'b1;
    for (int g = 6; g <= 9; g++) group(1, 24'(g * 1000), g == 9, 1'b1);
    idle(1);
    wait_empty(1);
    @(negedge sys_clk);
    chk("ovf_busy_end", 32'(busy8), 32'd0);
    chk("ovf_sticky",   32'(ovf8),  32'd1);
    start(1);
    idle(1);
    @(negedge sys_clk);
    chk("ovf_cleared", 32'(ovf8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lockin_frame_builder.md
LOCKIN_FRAME_BUILDER -- requirements
Module: lockin_frame_builder

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 4, log2 of the number of amplitude samples per average (range 1..8).
REQ-002 SHALL have parameter FRAME_LEN, default 64, number of averaged words per frame (range 2..1024).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in words (power of 2, at least 4).
REQ-004 sys_clk  input  1  single clock for all logic.
REQ-005 sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse that arms capture of one frame.
REQ-007 lock_tdata_valid  input  1  amplitude sample strobe from the lock-in amplifier.
REQ-008 lock_tdata  input  24  unsigned lock-in amplitude.
REQ-009 m_axis_tvalid  output  1  output word valid.
REQ-010 m_axis_tready  input  1  downstream (CNN feature loader) ready.
REQ-011 m_axis_tdata  output  24  averaged amplitude.
REQ-012 m_axis_tlast  output  1  marks the last word of a frame.
REQ-013 frame_busy  output  1  high from an accepted frame_start until the frame's last word is accepted downstream.
REQ-014 overflow  output  1  sticky flag: an average was dropped because the FIFO was full.

Function
REQ-015 SHALL use an FSM with states IDLE, COLLECT and DRAIN.
REQ-016 IDLE: frame_start moves the FSM to COLLECT, clears the accumulator, sample counter and word counter, and clears overflow. Samples are ignored in IDLE.
REQ-017 frame_start outside IDLE SHALL be ignored.
REQ-018 COLLECT: each cycle with lock_tdata_valid high adds lock_tdata to a (24+AVG_LOG2)-bit accumulator and increments the sample counter.
REQ-019 On the 2^AVG_LOG2-th sample, the clock edge SHALL register the average (accumulator plus current sample, shifted right by AVG_LOG2) and restart the accumulator at 0. No sample is lost between averages.
REQ-020 The registered average SHALL be written to the FIFO on the following edge, together with a tlast bit that is set when the word counter equals FRAME_LEN-1.
REQ-021 If the FIFO is full at write time, the word SHALL be dropped, overflow SHALL be set, and the word counter SHALL NOT advance.
REQ-022 After the FRAME_LEN-th word is written, the FSM SHALL go to DRAIN. Samples are ignored in DRAIN.
REQ-023 DRAIN: the FSM SHALL return to IDLE on the cycle the tlast word completes a handshake.
REQ-024 A handshake SHALL occur when m_axis_tvalid and m_axis_tready are both high. m_axis_tdata and m_axis_tlast SHALL hold stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-025 m_axis_tvalid SHALL be driven by a registered FIFO output. A word written into an empty FIFO at edge k SHALL appear at edge k+1.
REQ-026 Latency: the final sample of an average at edge k SHALL give m_axis_tvalid high after edge k+2 when the FIFO is empty.
REQ-027 Simultaneous FIFO write and read when the FIFO is full SHALL be allowed, with no drop.
REQ-028 The FIFO SHALL sustain one word per cycle when m_axis_tready is held high.

Reset
REQ-029 Asserting sys_rst_n low at any time SHALL asynchronously force: FSM to IDLE, accumulator and all counters to 0, FIFO empty, and m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_busy and overflow all to 0.
REQ-030 A frame in progress when reset is asserted SHALL be discarded. After reset releases, nothing SHALL be emitted until a new frame_start.

Configuration
REQ-031 Macro LOCKIN_AVG_ROUND_EN.
- Defined: average = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, saturated to 24'hFFFFFF.
- Undefined: average = sum >> AVG_LOG2 (truncation), with no rounding adder present.

Verification (AVG_LOG2=2, FRAME_LEN=4, FIFO_DEPTH=4)
REQ-032 Pulse frame_start, then 16 valid samples of 100, m_axis_tready=1 -> four words of 100, tlast on the 4th only, frame_busy falls after the 4th handshake.
REQ-033 Samples 1,2,3,4, macro undefined -> word 2. Same samples with macro defined -> word 3 (10+2=12, >>2).
REQ-034 Four samples of 24'hFFFFFF with macro defined -> word 24'hFFFFFF, no wrap.
REQ-035 m_axis_tready=0 through the whole frame, then 4 more samples fed after the frame -> 4 words held stable, overflow=0. Then tready=1 -> all 4 words delivered in order.
REQ-036 FIFO_DEPTH=4, FRAME_LEN=8, tready=0 -> 5th average dropped, overflow=1, frame still completes with 8 written words once tready rises.
REQ-037 Reset asserted after 6 samples, then released and 4 samples fed without frame_start -> m_axis_tvalid stays 0, all outputs 0.
